// File: rtl/convolution_coprocessor_mac_core.sv
// Convolution coprocessor MAC core: z[n] = sum_k x[k]*y[n-k], streamed to the result memory.
// Optional build macro CONV_SATURATE_EN: clamp each written z[n] to 2**OUT_WIDTH-1
// instead of truncating it to OUT_WIDTH bits.
// Memory read data is sampled one clock after the registered address is presented.
module convolution_coprocessor_mac_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   sizex_i,
    input  logic [ADDR_WIDTH:0]   sizey_i,
    output logic [ADDR_WIDTH-1:0] memx_addr_o,
    input  logic [DATA_WIDTH-1:0] memx_data_i,
    output logic [ADDR_WIDTH-1:0] memy_addr_o,
    input  logic [DATA_WIDTH-1:0] memy_data_i,
    output logic                  res_we_o,
    output logic [ADDR_WIDTH:0]   res_addr_o,
    output logic [OUT_WIDTH-1:0]  res_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int unsigned SZ_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned N_WIDTH   = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_MAC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [SZ_WIDTH-1:0]   r_sizex;
    logic [SZ_WIDTH-1:0]   r_sizey;
    logic [SZ_WIDTH-1:0]   r_n;
    logic [SZ_WIDTH-1:0]   r_k;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ADDR_WIDTH-1:0] r_memx_addr;
    logic [ADDR_WIDTH-1:0] r_memy_addr;
    logic                  r_res_we;
    logic [SZ_WIDTH-1:0]   r_res_addr;
    logic [OUT_WIDTH-1:0]  r_res_data;
    logic                  r_busy;
    logic                  r_done;

    logic [N_WIDTH-1:0]    w_n_p1;
    logic [SZ_WIDTH-1:0]   w_kmin;
    logic [SZ_WIDTH-1:0]   w_kmax;
    logic [SZ_WIDTH-1:0]   w_k_nxt;
    logic [SZ_WIDTH-1:0]   w_last;
    logic [ACC_WIDTH-1:0]  w_prod;
    logic [ACC_WIDTH-1:0]  w_acc_sum;
    logic [OUT_WIDTH-1:0]  w_res;

    // Term range for the current n and the index of the final output sample
    assign w_n_p1    = N_WIDTH'(r_n) + N_WIDTH'(1);
    assign w_kmin    = (w_n_p1 > N_WIDTH'(r_sizey)) ? SZ_WIDTH'(w_n_p1 - N_WIDTH'(r_sizey)) : '0;
    assign w_kmax    = (r_n < r_sizex) ? r_n : (r_sizex - SZ_WIDTH'(1));
    assign w_k_nxt   = r_k + SZ_WIDTH'(1);
    assign w_last    = SZ_WIDTH'(N_WIDTH'(r_sizex) + N_WIDTH'(r_sizey) - N_WIDTH'(2));

    // Product of the samples addressed last cycle, added into the running sum
    assign w_prod    = ACC_WIDTH'(memx_data_i) * ACC_WIDTH'(memy_data_i);
    assign w_acc_sum = r_acc + w_prod;

`ifdef CONV_SATURATE_EN
    // Clamp sums that do not fit the result word
    assign w_res = (w_acc_sum > ACC_WIDTH'({OUT_WIDTH{1'b1}})) ? {OUT_WIDTH{1'b1}}
                                                                : w_acc_sum[OUT_WIDTH-1:0];
`else
    // Keep the low result bits of the sum
    assign w_res = w_acc_sum[OUT_WIDTH-1:0];
`endif

    // Control FSM with the accumulator, address and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_sizex     <= '0;
            r_sizey     <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_memx_addr <= '0;
            r_memy_addr <= '0;
            r_res_we    <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_res_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_sizex <= sizex_i;
                        r_sizey <= sizey_i;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_n <= '0;
                    if ((r_sizex == '0) || (r_sizey == '0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_k         <= w_kmin;
                    r_memx_addr <= ADDR_WIDTH'(w_kmin);
                    r_memy_addr <= ADDR_WIDTH'(r_n - w_kmin);
                    r_acc       <= '0;
                    r_state     <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (r_k == w_kmax) begin
                        r_res_we   <= 1'b1;
                        r_res_addr <= r_n;
                        r_res_data <= w_res;
                        r_state    <= S_WRITE;
                    end else begin
                        r_k         <= w_k_nxt;
                        r_memx_addr <= ADDR_WIDTH'(w_k_nxt);
                        r_memy_addr <= ADDR_WIDTH'(r_n - w_k_nxt);
                    end
                end
                S_WRITE: begin
                    if (r_n == w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n     <= r_n + SZ_WIDTH'(1);
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign memx_addr_o = r_memx_addr;
    assign memy_addr_o = r_memy_addr;
    assign res_we_o    = r_res_we;
    assign res_addr_o  = r_res_addr;
    assign res_data_o  = r_res_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_convolution_coprocessor_mac_core.sv
// Self-checking bench for convolution_coprocessor_mac_core: direct convolution model plus
// a write scoreboard; the memories answer combinationally from the registered addresses.
module tb_convolution_coprocessor_mac_core;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic [5:0]  sizex_i;
    logic [5:0]  sizey_i;
    logic [4:0]  memx_addr_o;
    logic [7:0]  memx_data_i;
    logic [4:0]  memy_addr_o;
    logic [7:0]  memy_data_i;
    logic        res_we_o;
    logic [5:0]  res_addr_o;
    logic [15:0] res_data_o;
    logic        busy_o;
    logic        done_o;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic [7:0]  mem_x [32];
    logic [7:0]  mem_y [32];
    logic [15:0] got_data [64];
    wr_t         exp_q [$];
    int          n_cmp;
    int          n_err;
    int          n_writes;
    int          n_done;
    bit          mon_en;
    logic [5:0]  last_addr;
    logic [15:0] last_data;

    convolution_coprocessor_mac_core #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .OUT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start_i(start_i),
        .sizex_i(sizex_i),
        .sizey_i(sizey_i),
        .memx_addr_o(memx_addr_o),
        .memx_data_i(memx_data_i),
        .memy_addr_o(memy_addr_o),
        .memy_data_i(memy_data_i),
        .res_we_o(res_we_o),
        .res_addr_o(res_addr_o),
        .res_data_o(res_data_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memx_data_i = mem_x[memx_addr_o];
    assign memy_data_i = mem_y[memy_addr_o];

    // Direct convolution of the sample memories, reduced to the result word
    function automatic logic [15:0] model_z(input int n, input int sx, input int sy);
        longint acc;
        acc = 0;
        for (int k = 0; k < sx; k++) begin
            if ((n - k >= 0) && (n - k < sy)) acc += longint'(mem_x[k]) * longint'(mem_y[n - k]);
        end
`ifdef CONV_SATURATE_EN
        if (acc > 65535) return 16'hFFFF;
`endif
        return 16'(acc);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every write, every idle hold and every done pulse is checked
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (res_we_o) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_write addr=%0d data=%0d expected no write", res_addr_o, res_data_o);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        if ((res_addr_o !== e.addr) || (res_data_o !== e.data)) begin
                            n_err++;
                            $display("FAIL write actual addr=%0d data=%0d expected addr=%0d data=%0d",
                                     res_addr_o, res_data_o, e.addr, e.data);
                        end
                    end
                    chk("busy_during_write", longint'(busy_o), 1);
                    got_data[res_addr_o] = res_data_o;
                    last_addr = res_addr_o;
                    last_data = res_data_o;
                    n_writes++;
                end else if (rstn) begin
                    n_cmp++;
                    if ((res_addr_o !== last_addr) || (res_data_o !== last_data)) begin
                        n_err++;
                        $display("FAIL result_hold actual addr=%0d data=%0d expected addr=%0d data=%0d",
                                 res_addr_o, res_data_o, last_addr, last_data);
                    end
                end
                if (done_o) begin
                    n_done++;
                    chk("done_pending_writes", longint'(exp_q.size()), 0);
                    chk("busy_at_done", longint'(busy_o), 0);
                end
            end
            if (!rstn) begin
                last_addr = '0;
                last_data = '0;
            end
        end
    end

    task automatic fill_ramp(input int sx, input int sy, input int vx, input int vy);
        for (int i = 0; i < 32; i++) begin
            mem_x[i] = (i < sx) ? 8'(vx) : 8'($urandom);
            mem_y[i] = (i < sy) ? 8'(vy) : 8'($urandom);
        end
    endtask

    task automatic load_expected(input int sx, input int sy);
        wr_t e;
        exp_q.delete();
        if ((sx > 0) && (sy > 0)) begin
            for (int n = 0; n <= sx + sy - 2; n++) begin
                e.addr = 6'(n);
                e.data = model_z(n, sx, sy);
                exp_q.push_back(e);
            end
        end
        n_writes = 0;
        n_done   = 0;
    endtask

    task automatic pulse_start(input int sx, input int sy);
        @(negedge clk); #1;
        start_i = 1'b1;
        sizex_i = 6'(sx);
        sizey_i = 6'(sy);
        @(negedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", longint'(busy_o), 1);
    endtask

    // One convolution; optionally disturbs start/size inputs while busy
    task automatic run(input int sx, input int sy, input bit disturb);
        int c;
        load_expected(sx, sy);
        pulse_start(sx, sy);
        c = 1;
        while ((n_done == 0) && (c < 5000)) begin
            if (disturb && (c == 4)) begin
                start_i = 1'b1;
                sizex_i = 6'($urandom_range(0, 32));
                sizey_i = 6'($urandom_range(0, 32));
            end
            if (disturb && (c == 5)) start_i = 1'b0;
            @(negedge clk); #1;
            c++;
        end
        start_i = 1'b0;
        chk("done_seen", longint'(n_done), 1);
        if ((sx == 0) || (sy == 0)) chk("zero_size_done_latency_ok", longint'(c <= 3), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_after_done", longint'(busy_o), 0);
        chk("single_done", longint'(n_done), 1);
        chk("write_count", longint'(n_writes), (sx > 0 && sy > 0) ? sx + sy - 1 : 0);
    endtask

    task automatic check_test1(input string tag);
        logic [15:0] exp1 [4];
        exp1[0] = 16'd1; exp1[1] = 16'd3; exp1[2] = 16'd5; exp1[3] = 16'd3;
        for (int i = 0; i < 4; i++) chk($sformatf("%s_z%0d", tag, i), longint'(got_data[i]), longint'(exp1[i]));
    endtask

    initial begin
        int c;
        int sx;
        int sy;
        n_cmp = 0; n_err = 0; n_writes = 0; n_done = 0;
        mon_en = 1'b0; last_addr = '0; last_data = '0;
        rstn = 1'b0; start_i = 1'b0; sizex_i = '0; sizey_i = '0;
        for (int i = 0; i < 64; i++) got_data[i] = '0;
        fill_ramp(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_we", longint'(res_we_o), 0);
        chk("reset_addr", longint'(res_addr_o), 0);
        chk("reset_data", longint'(res_data_o), 0);
        chk("reset_busy", longint'(busy_o), 0);
        chk("reset_done", longint'(done_o), 0);
        chk("reset_memx_addr", longint'(memx_addr_o), 0);
        chk("reset_memy_addr", longint'(memy_addr_o), 0);
        #1;
        rstn = 1'b1;
        mon_en = 1'b1;

        // X=[1,2,3], Y=[1,1]
        fill_ramp(3, 2, 1, 1);
        mem_x[1] = 8'd2; mem_x[2] = 8'd3;
        run(3, 2, 1'b0);
        check_test1("t1");

        // Single-sample sequences
        fill_ramp(1, 1, 5, 7);
        run(1, 1, 1'b0);
        chk("t2_z0", longint'(got_data[0]), 35);

        // Full-length all-255 sequences
        fill_ramp(32, 32, 255, 255);
        run(32, 32, 1'b0);
`ifdef CONV_SATURATE_EN
        chk("t3_z31", longint'(got_data[31]), 65535);
`else
        chk("t3_z31", longint'(got_data[31]), 49184);
`endif
        chk("t3_z0", longint'(got_data[0]), 65025);

        // Empty X: no writes, immediate done
        fill_ramp(0, 4, 0, 3);
        run(0, 4, 1'b0);

        // Start and size changes while busy are ignored
        fill_ramp(3, 2, 1, 1);
        mem_x[1] = 8'd2; mem_x[2] = 8'd3;
        for (int i = 0; i < 4; i++) got_data[i] = '0;
        run(3, 2, 1'b1);
        check_test1("t5");

        // Reset during accumulation of n=2, then a clean rerun
        load_expected(3, 2);
        pulse_start(3, 2);
        c = 0;
        while ((n_writes < 2) && (c < 200)) begin
            @(negedge clk); #1;
            c++;
        end
        chk("t6_reached_n2", longint'(n_writes), 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        chk("t6_rst_we", longint'(res_we_o), 0);
        chk("t6_rst_data", longint'(res_data_o), 0);
        chk("t6_rst_addr", longint'(res_addr_o), 0);
        chk("t6_rst_busy", longint'(busy_o), 0);
        chk("t6_rst_memx", longint'(memx_addr_o), 0);
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_writes_after_abort", longint'(n_writes), 2);
        chk("t6_no_done_after_abort", longint'(n_done), 0);
        for (int i = 0; i < 4; i++) got_data[i] = '0;
        run(3, 2, 1'b0);
        check_test1("t6");

        // Random sizes and samples
        for (int r = 0; r < 10; r++) begin
            sx = (r == 0) ? 32 : int'($urandom_range(0, 32));
            sy = (r == 1) ? 0 : int'($urandom_range(0, 32));
            for (int i = 0; i < 32; i++) begin
                mem_x[i] = 8'($urandom);
                mem_y[i] = 8'($urandom);
            end
            run(sx, sy, r[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
